pipelined_muldiv_alu: RTL
=========================

Name: pipelined_muldiv_alu

Overview:
Sequential, parametrised execution unit for the RISC-V core. It replaces the purely combinational integer ALU with one block that does three things:
- single-cycle integer, shift, compare and branch-condition ops, all with registered results;
- iterative multi-cycle RV32M multiply, divide and remainder;
- a valid/ready handshake on both sides, so the multi-cycle control unit can stall on long ops.

Parameters:
DATA_WIDTH, 32, operand/result width; must be >= 4 and a power of two.
SHAMT_WIDTH, $clog2(DATA_WIDTH), number of low operand-2 bits used as the shift amount.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept a request this cycle.
alu_op  input  5  operation code (table below).
alu_in_1  input  DATA_WIDTH  operand 1 (rs1 / dividend / multiplicand).
alu_in_2  input  DATA_WIDTH  operand 2 (rs2 / imm / divisor / multiplier).
kill  input  1  abort any in-flight operation (pipeline flush).
out_valid  output  1  alu_result and alu_bcond are valid.
out_ready  input  1  consumer takes the result this cycle.
alu_result  output  DATA_WIDTH  registered result.
alu_bcond  output  1  registered branch condition; 0 for non-branch ops.
busy  output  1  high while in state ITER.

Behaviour:
Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
- 5 SLL, 6 SRL, 7 SRA
- 8 SLT, 9 SLTU
- 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
- 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU
- 20 DIV, 21 DIVU, 22 REM, 23 REMU
- 24-31: illegal; result 0, bcond 0, single-cycle.

States: IDLE, ITER, DONE.
- Reset: state IDLE; alu_result=0, alu_bcond=0, out_valid=0, busy=0, iteration counter 0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A handshake is in_valid && in_ready; operands and op are captured on that edge.
- Single-cycle op (0-15, 24-31): the accept edge goes to DONE with the result registered; out_valid is high the next cycle (latency 1).
- Multi-cycle op (16-23): the accept edge goes to ITER with counter=DATA_WIDTH.
  - One shift-add (multiply) or restoring-divide step is done per cycle.
  - When the counter reaches 0, the unit moves to DONE. out_valid rises exactly DATA_WIDTH+1 cycles after the accept edge.
- DONE: alu_result, alu_bcond and out_valid hold until out_ready=1.
  - Result taken and no new accept: go to IDLE.
  - Result taken and in_valid=1 on the same edge: accept the new op back-to-back. No bubble; out_valid stays high for a single-cycle op.
- kill=1: state returns to IDLE next edge and out_valid drops; no request is accepted that cycle. kill has priority over in_valid and out_ready; reset has priority over everything.

Arithmetic rules:
- ADD/SUB wrap modulo 2^DATA_WIDTH.
- Shifts use alu_in_2[SHAMT_WIDTH-1:0] only; SRA sign-fills.
- SLT/SLTU return 1 or 0 zero-extended.
- Signed compares treat operands as two's complement. BGE is true when in_1 >= in_2, including equality; the same holds for BGEU.
- MUL returns the low DATA_WIDTH bits of the product. MULH, MULHSU and MULHU return the high half of the 2*DATA_WIDTH product under signed×signed, signed×unsigned and unsigned×unsigned interpretation.
- Division by zero:
  - DIV/DIVU: quotient = all ones.
  - REM/REMU: remainder = dividend.
  - Latency is still DATA_WIDTH+1 cycles.
- Signed overflow (most-negative / -1): DIV returns the most-negative value; REM returns 0.
- Signed divide: operate on magnitudes, then negate the quotient if signs differ and negate the remainder if the dividend is negative.

Operands presented while the unit is not ready are ignored and are not latched. alu_bcond is 0 for every non-branch op.

Test Plan:
1. Reset held 2 cycles with in_valid=1 -> out_valid=0, alu_result=0, in_ready=1 after release. Then ADD 7,5 -> alu_result=12 with out_valid one cycle after accept.
2. BGE 5,5 -> bcond=1. BLT 0xFFFFFFFF,1 -> bcond=1. BLTU 0xFFFFFFFF,1 -> bcond=0. SRA 0x80000000 by 36 -> 0xF8000000 (shamt 4).
3. MULH 0x80000000,0x80000000 -> 0x40000000 and MULHU -> 0x40000000. MUL 0xFFFFFFFF,3 -> 0xFFFFFFFD. Each arrives exactly 33 cycles after accept, with busy high for 32 cycles.
4. Divide edge cases:
   - DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
   - DIVU 9,0 -> 0xFFFFFFFF; REMU 9,0 -> 9.
   - DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF.
5. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> result stable and in_ready=0. Then raise out_ready with a new ADD valid on the same cycle -> the new op is accepted on that edge with no idle cycle.
6. Start DIVU, assert kill at iteration 10 -> IDLE next cycle, out_valid never rises for the DIVU. A following SUB 3,5 -> 0xFFFFFFFE.

Source files
------------

// File: rtl/pipelined_muldiv_alu.sv
// Execution unit: registered single-cycle ALU/branch ops plus iterative RV32M
// multiply/divide, with valid/ready handshakes on both the request and result sides.
module pipelined_muldiv_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_in_1,
  input  logic [DATA_WIDTH-1:0] alu_in_2,
  input  logic                  kill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  alu_bcond,
  output logic                  busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [W-1:0]    r_result, r_hi, r_lo, r_opd;
  logic            r_bcond, r_neg;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;

  logic                   w_accept, w_multi, w_s1, w_s2, w_neg1, w_neg2, w_neg_in;
  logic [W-1:0]           w_mag1, w_mag2, w_sc_res;
  logic                   w_sc_bc;
  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic [W:0]             w_sum;
  logic [W-1:0]           w_trial, w_hi_nx, w_lo_nx, w_divr, w_divr_s, w_fin;
  logic                   w_ge;
  logic [2*W-1:0]         w_prod, w_prod_s;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
  assign w_accept  = in_valid && in_ready && !kill;
  assign w_multi   = (alu_op[4:3] == 2'b10);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ITER);
  assign alu_result = r_result;
  assign alu_bcond  = r_bcond;

  // Signed ops run on magnitudes; the sign fix-up is applied to the final value.
  assign w_s1   = (alu_op == 5'd17) || (alu_op == 5'd18) || (alu_op == 5'd20) || (alu_op == 5'd22);
  assign w_s2   = (alu_op == 5'd17) || (alu_op == 5'd20) || (alu_op == 5'd22);
  assign w_neg1 = w_s1 && alu_in_1[W-1];
  assign w_neg2 = w_s2 && alu_in_2[W-1];
  assign w_mag1 = w_neg1 ? -alu_in_1 : alu_in_1;
  assign w_mag2 = w_neg2 ? -alu_in_2 : alu_in_2;
  // Remainder follows the dividend; a zero-divisor quotient stays all ones.
  assign w_neg_in = !alu_op[2] ? (w_neg1 ^ w_neg2) :
                    alu_op[1]  ? w_neg1 : ((w_neg1 ^ w_neg2) && (alu_in_2 != '0));

  assign w_shamt = alu_in_2[SHAMT_WIDTH-1:0];

  always_comb begin
    w_sc_res = '0;
    w_sc_bc  = 1'b0;
    case (alu_op)
      5'd0:  w_sc_res = alu_in_1 + alu_in_2;
      5'd1:  w_sc_res = alu_in_1 - alu_in_2;
      5'd2:  w_sc_res = alu_in_1 & alu_in_2;
      5'd3:  w_sc_res = alu_in_1 | alu_in_2;
      5'd4:  w_sc_res = alu_in_1 ^ alu_in_2;
      5'd5:  w_sc_res = alu_in_1 << w_shamt;
      5'd6:  w_sc_res = alu_in_1 >> w_shamt;
      5'd7:  w_sc_res = $signed(alu_in_1) >>> w_shamt;
      5'd8:  w_sc_res = {{(W-1){1'b0}}, $signed(alu_in_1) < $signed(alu_in_2)};
      5'd9:  w_sc_res = {{(W-1){1'b0}}, alu_in_1 < alu_in_2};
      5'd10: w_sc_bc  = (alu_in_1 == alu_in_2);
      5'd11: w_sc_bc  = (alu_in_1 != alu_in_2);
      5'd12: w_sc_bc  = ($signed(alu_in_1) <  $signed(alu_in_2));
      5'd13: w_sc_bc  = ($signed(alu_in_1) >= $signed(alu_in_2));
      5'd14: w_sc_bc  = (alu_in_1 <  alu_in_2);
      5'd15: w_sc_bc  = (alu_in_1 >= alu_in_2);
      default: ;
    endcase
  end

  // One iteration: shift-add for multiply ({hi,lo} = partial product, lo = multiplier),
  // restoring divide (hi = partial remainder, lo = dividend shifting into quotient).
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
  assign w_ge    = ({r_hi, r_lo[W-1]} >= {1'b0, r_opd});
  assign w_trial = {r_hi[W-2:0], r_lo[W-1]} - r_opd;
  assign w_hi_nx = r_op[2] ? (w_ge ? w_trial : {r_hi[W-2:0], r_lo[W-1]}) : w_sum[W:1];
  assign w_lo_nx = r_op[2] ? {r_lo[W-2:0], w_ge} : {w_sum[0], r_lo[W-1:1]};

  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_divr   = r_op[1] ? w_hi_nx : w_lo_nx;
  assign w_divr_s = r_neg ? -w_divr : w_divr;
  assign w_fin    = r_op[2] ? w_divr_s :
                    (r_op[1:0] == 2'b00) ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W];

  always_comb begin
    w_state_nx = r_state;
    if (kill) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) w_state_nx = w_multi ? S_ITER : S_DONE;
        S_ITER: if (r_cnt == CW'(1)) w_state_nx = S_DONE;
        S_DONE: if (out_ready) w_state_nx = in_valid ? (w_multi ? S_ITER : S_DONE) : S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_bcond  <= 1'b0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opd    <= '0;
    end else begin
      r_state <= w_state_nx;
      if (kill) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_op <= alu_op[2:0];
        if (w_multi) begin
          r_cnt <= CW'(W);
          r_neg <= w_neg_in;
          r_hi  <= '0;
          r_lo  <= alu_op[2] ? w_mag1 : w_mag2;
          r_opd <= alu_op[2] ? w_mag2 : w_mag1;
        end else begin
          r_result <= w_sc_res;
          r_bcond  <= w_sc_bc;
        end
      end else if (r_state == S_ITER) begin
        r_hi  <= w_hi_nx;
        r_lo  <= w_lo_nx;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_result <= w_fin;
          r_bcond  <= 1'b0;
        end
      end
    end
  end
endmodule
